// File: rtl/pdp8_membus_ctrl.sv
// Memory/IO bus sequencer for the pin-limited PDP-8: serialises one 12-bit
// request into address (or IO-select) phases plus three nibble data phases.
module pdp8_membus_ctrl #(
    parameter int WAIT_STATES = 0,
    parameter bit HI_CACHE    = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic        io,
    input  logic [4:0]  io_dev,
    input  logic [11:0] addr,
    input  logic [11:0] wdata,
    output logic        ack,
    output logic        busy,
    output logic [11:0] rdata,
    output logic [7:0]  bus_out,
    input  logic [3:0]  bus_in
);

    localparam logic [3:0] LAST_WAIT = 4'(WAIT_STATES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR_HI,
        S_ADDR_LO,
        S_IO_SEL,
        S_NIB,
        S_DONE
    } state_t;

    state_t      state, state_n;
    logic [1:0]  k, k_n;
    logic [3:0]  wcnt, wcnt_n;
    logic        accept;

    logic        we_r, we_n;
    logic [4:0]  dev_r, dev_n;
    logic [11:0] addr_r, addr_n;
    logic [11:0] wdata_r, wdata_n;
    logic [5:0]  last_hi;
    logic        hi_valid;
    logic [5:0]  last_lo, last_lo_n;
    logic [7:0]  rbuf;
    logic [3:0]  nib_n;
    logic        strobe_n;
    logic [7:0]  bus_n;

    assign ack  = (state == S_DONE);
    assign busy = (state != S_IDLE);

    always_comb begin
        state_n = state;
        k_n     = k;
        wcnt_n  = wcnt;
        accept  = 1'b0;
        case (state)
            S_IDLE: begin
                if (req) begin
                    accept = 1'b1;
                    if (io)
                        state_n = S_IO_SEL;
                    else if (HI_CACHE && hi_valid && addr[11:6] == last_hi)
                        state_n = S_ADDR_LO;
                    else
                        state_n = S_ADDR_HI;
                end
            end
            S_ADDR_HI: state_n = S_ADDR_LO;
            S_ADDR_LO, S_IO_SEL: begin
                state_n = S_NIB;
                k_n     = 2'd0;
                wcnt_n  = 4'd0;
            end
            S_NIB: begin
                if (wcnt == LAST_WAIT) begin
                    wcnt_n = 4'd0;
                    if (k == 2'd2)
                        state_n = S_DONE;
                    else
                        k_n = k + 2'd1;
                end else begin
                    wcnt_n = wcnt + 4'd1;
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase

        // bus_out is registered, so encode from the values the next cycle will hold
        we_n      = accept ? we     : we_r;
        dev_n     = accept ? io_dev : dev_r;
        addr_n    = accept ? addr   : addr_r;
        wdata_n   = accept ? wdata  : wdata_r;
        last_lo_n = (state_n == S_ADDR_LO) ? addr_n[5:0] : last_lo;

        case (k_n)
            2'd0:    nib_n = wdata_n[11:8];
            2'd1:    nib_n = wdata_n[7:4];
            default: nib_n = wdata_n[3:0];
        endcase
        strobe_n = !(we_n && wcnt_n == LAST_WAIT);

        case (state_n)
            S_ADDR_HI: bus_n = {2'b11, addr_n[11:6]};
            S_ADDR_LO: bus_n = {2'b10, addr_n[5:0]};
            S_IO_SEL:  bus_n = {3'b011, dev_n};
            S_NIB:     bus_n = {1'b0, k_n, strobe_n, (we_n ? nib_n : 4'h0)};
            default:   bus_n = {2'b10, last_lo_n};
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            k        <= 2'd0;
            wcnt     <= 4'd0;
            we_r     <= 1'b0;
            dev_r    <= 5'd0;
            addr_r   <= 12'd0;
            wdata_r  <= 12'd0;
            last_hi  <= 6'd0;
            hi_valid <= 1'b0;
            last_lo  <= 6'd0;
            rbuf     <= 8'd0;
            rdata    <= 12'd0;
            bus_out  <= 8'b1000_0000;
        end else begin
            state   <= state_n;
            k       <= k_n;
            wcnt    <= wcnt_n;
            we_r    <= we_n;
            dev_r   <= dev_n;
            addr_r  <= addr_n;
            wdata_r <= wdata_n;
            last_lo <= last_lo_n;
            bus_out <= bus_n;
            if (state_n == S_ADDR_HI) begin
                last_hi  <= addr_n[11:6];
                hi_valid <= 1'b1;
            end
            // rdata only changes together with the ack, so assemble in rbuf first
            if (state == S_NIB && !we_r && wcnt == LAST_WAIT) begin
                case (k)
                    2'd0:    rbuf[7:4] <= bus_in;
                    2'd1:    rbuf[3:0] <= bus_in;
                    default: rdata     <= {rbuf, bus_in};
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pdp8_membus_ctrl.sv
// Bench for pdp8_membus_ctrl: two instances (0 and 2 wait states) share the
// request inputs; each answers reads from a nibble model keyed on its bus_out.
module tb_pdp8_membus_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        we;
    logic        io;
    logic [4:0]  io_dev;
    logic [11:0] addr;
    logic [11:0] wdata;
    logic [11:0] rword;

    logic        ack_a   [2];
    logic        busy_a  [2];
    logic [11:0] rdata_a [2];
    logic [7:0]  bus_out_a [2];
    logic [3:0]  bus_in_a  [2];

    always #5 clk = ~clk;

    function automatic logic [3:0] nib_of(input logic [11:0] v, input logic [1:0] kk);
        case (kk)
            2'd0:    return v[11:8];
            2'd1:    return v[7:4];
            default: return v[3:0];
        endcase
    endfunction

    assign bus_in_a[0] = nib_of(rword, bus_out_a[0][6:5]);
    assign bus_in_a[1] = nib_of(rword, bus_out_a[1][6:5]);

    pdp8_membus_ctrl #(.WAIT_STATES(0), .HI_CACHE(1'b1)) dut0 (
        .clk(clk), .rst(rst), .req(req), .we(we), .io(io), .io_dev(io_dev),
        .addr(addr), .wdata(wdata), .ack(ack_a[0]), .busy(busy_a[0]),
        .rdata(rdata_a[0]), .bus_out(bus_out_a[0]), .bus_in(bus_in_a[0])
    );

    pdp8_membus_ctrl #(.WAIT_STATES(2), .HI_CACHE(1'b1)) dut2 (
        .clk(clk), .rst(rst), .req(req), .we(we), .io(io), .io_dev(io_dev),
        .addr(addr), .wdata(wdata), .ack(ack_a[1]), .busy(busy_a[1]),
        .rdata(rdata_a[1]), .bus_out(bus_out_a[1]), .bus_in(bus_in_a[1])
    );

    typedef struct packed {
        logic [11:0] rdata;
        logic [7:0]  lat;
    } exp_t;

    exp_t sb_q0[$];
    exp_t sb_q1[$];

    int n_cmp = 0;
    int n_bad = 0;

    logic        m_hi_valid;
    logic [5:0]  m_last_hi;
    logic [5:0]  m_last_lo;
    logic [11:0] m_rdata;

    function automatic int w_of(input int l);
        return (l == 0) ? 0 : 2;
    endfunction

    task automatic check_eq(input string tag, input logic [11:0] got, input logic [11:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected bus_out c cycles after the accept edge
    function automatic logic [7:0] exp_bus(input int w, input logic t_we, input logic t_io,
                                           input logic hit, input logic [4:0] dev,
                                           input logic [11:0] a, input logic [11:0] wd,
                                           input logic [5:0] lo_after, input int c);
        int         base;
        int         idx;
        logic [1:0] kk;
        logic       strobe;
        if (t_io) begin
            if (c == 1) return {3'b011, dev};
            base = 2;
        end else if (hit) begin
            if (c == 1) return {2'b10, a[5:0]};
            base = 2;
        end else begin
            if (c == 1) return {2'b11, a[11:6]};
            if (c == 2) return {2'b10, a[5:0]};
            base = 3;
        end
        idx = c - base;
        if (idx >= 0 && idx < 3 * (w + 1)) begin
            kk     = 2'(idx / (w + 1));
            strobe = t_we ? ((idx % (w + 1)) != w) : 1'b1;
            return {1'b0, kk, strobe, (t_we ? nib_of(wd, kk) : 4'h0)};
        end
        return {2'b10, lo_after};
    endfunction

    task automatic run_txn(input logic t_we, input logic t_io, input logic [4:0] t_dev,
                           input logic [11:0] t_addr, input logic [11:0] t_wdata,
                           input logic [11:0] t_rword);
        logic       hit;
        logic [5:0] lo_after;
        bit         done [2];
        exp_t       e;
        hit = !t_io && m_hi_valid && (t_addr[11:6] == m_last_hi);
        for (int l = 0; l < 2; l++) begin
            e.rdata = t_we ? m_rdata : t_rword;
            e.lat   = 8'((t_io || hit) ? 5 + 3 * w_of(l) : 6 + 3 * w_of(l));
            if (l == 0) sb_q0.push_back(e);
            else        sb_q1.push_back(e);
        end
        if (!t_io) begin
            m_hi_valid = 1'b1;
            m_last_hi  = t_addr[11:6];
            m_last_lo  = t_addr[5:0];
        end
        if (!t_we) m_rdata = t_rword;
        lo_after = m_last_lo;

        @(negedge clk);
        req = 1'b1; we = t_we; io = t_io; io_dev = t_dev;
        addr = t_addr; wdata = t_wdata; rword = t_rword;
        @(posedge clk);
        #1;
        req    = 1'b0;
        we     = 1'($urandom);
        io     = 1'($urandom);
        io_dev = 5'($urandom);
        addr   = 12'($urandom);
        wdata  = 12'($urandom);

        done[0] = 1'b0;
        done[1] = 1'b0;
        for (int c = 1; c <= 40 && !(done[0] && done[1]); c++) begin
            @(negedge clk);
            for (int l = 0; l < 2; l++) begin
                if (!done[l]) begin
                    check_eq($sformatf("l%0d_bus_c%0d", l, c), 12'(bus_out_a[l]),
                             12'(exp_bus(w_of(l), t_we, t_io, hit, t_dev, t_addr, t_wdata, lo_after, c)));
                    check_eq($sformatf("l%0d_busy_c%0d", l, c), 12'(busy_a[l]), 12'd1);
                    if (ack_a[l]) begin
                        done[l] = 1'b1;
                        if (l == 0) e = sb_q0.pop_front();
                        else        e = sb_q1.pop_front();
                        check_eq($sformatf("l%0d_ack_lat", l), 12'(c), 12'(e.lat));
                        check_eq($sformatf("l%0d_rdata", l), rdata_a[l], e.rdata);
                    end
                end
            end
        end
        for (int l = 0; l < 2; l++) begin
            if (!done[l]) begin
                check_eq($sformatf("l%0d_ack_timeout", l), 12'd0, 12'd1);
                if (l == 0) e = sb_q0.pop_front();
                else        e = sb_q1.pop_front();
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int prev_ack [2];
        int ack_cnt  [2];
        bit idle_ok;

        rst = 1'b1; req = 1'b0; we = 1'b0; io = 1'b0; io_dev = 5'd0;
        addr = 12'd0; wdata = 12'd0; rword = 12'd0;
        m_hi_valid = 1'b0; m_last_hi = 6'd0; m_last_lo = 6'd0; m_rdata = 12'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int l = 0; l < 2; l++) begin
            check_eq($sformatf("l%0d_rst_bus", l), 12'(bus_out_a[l]), 12'h080);
            check_eq($sformatf("l%0d_rst_ack", l), 12'(ack_a[l]), 12'd0);
            check_eq($sformatf("l%0d_rst_busy", l), 12'(busy_a[l]), 12'd0);
            check_eq($sformatf("l%0d_rst_rdata", l), rdata_a[l], 12'd0);
        end

        // miss read, same-half hit read, miss write, IO read, hit read after IO
        run_txn(1'b0, 1'b0, 5'd0,    12'o1234, 12'h000, 12'h5A3);
        run_txn(1'b0, 1'b0, 5'd0,    12'h2A0,  12'h000, 12'hC71);
        run_txn(1'b1, 1'b0, 5'd0,    12'h000,  12'hF0C, 12'h9E2);
        run_txn(1'b0, 1'b1, 5'h13,   12'h7FF,  12'h000, 12'h3B6);
        run_txn(1'b0, 1'b0, 5'd0,    12'h03F,  12'h000, 12'h48D);
        run_txn(1'b1, 1'b1, 5'h05,   12'h000,  12'hA5A, 12'h111);

        for (int i = 0; i < 8; i++) begin
            run_txn(1'($urandom), ($urandom_range(0, 3) == 0), 5'($urandom),
                    {($urandom_range(0, 1) == 1) ? 6'h0A : 6'h00, 6'($urandom_range(0, 63))},
                    12'($urandom), 12'($urandom));
        end

        // reset during NIB k=1 of the zero-wait instance
        @(negedge clk);
        req = 1'b1; we = 1'b0; io = 1'b0; addr = 12'h123; rword = 12'hBEE;
        @(posedge clk);
        #1;
        req = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("l0_pre_rst_nib1", 12'(bus_out_a[0]), 12'h030);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_hi_valid = 1'b0; m_last_lo = 6'd0; m_rdata = 12'd0;
        for (int l = 0; l < 2; l++) begin
            check_eq($sformatf("l%0d_abort_bus", l), 12'(bus_out_a[l]), 12'h080);
            check_eq($sformatf("l%0d_abort_ack", l), 12'(ack_a[l]), 12'd0);
            check_eq($sformatf("l%0d_abort_rdata", l), rdata_a[l], 12'd0);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            for (int l = 0; l < 2; l++)
                check_eq($sformatf("l%0d_abort_noack", l), 12'(ack_a[l]), 12'd0);
        end
        run_txn(1'b0, 1'b0, 5'd0, 12'h123, 12'h000, 12'h6D4);

        // req held high: each ack followed by exactly one idle cycle
        run_txn(1'b0, 1'b0, 5'd0, 12'h2C5, 12'h000, 12'h101);
        @(negedge clk);
        req = 1'b1; we = 1'b0; io = 1'b0; addr = 12'h2C5; rword = 12'hE37;
        m_rdata = 12'hE37;
        for (int l = 0; l < 2; l++) begin
            prev_ack[l] = -1;
            ack_cnt[l]  = 0;
        end
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            for (int l = 0; l < 2; l++) begin
                if (prev_ack[l] >= 0 && c == prev_ack[l] + 1)
                    check_eq($sformatf("l%0d_b2b_idle", l), 12'(busy_a[l]), 12'd0);
                if (ack_a[l]) begin
                    if (prev_ack[l] < 0)
                        check_eq($sformatf("l%0d_b2b_first", l), 12'(c), 12'(5 + 3 * w_of(l)));
                    else
                        check_eq($sformatf("l%0d_b2b_gap", l), 12'(c - prev_ack[l]),
                                 12'(6 + 3 * w_of(l)));
                    check_eq($sformatf("l%0d_b2b_rdata", l), rdata_a[l], 12'hE37);
                    prev_ack[l] = c;
                    ack_cnt[l]++;
                end
            end
        end
        req = 1'b0;
        for (int l = 0; l < 2; l++)
            check_eq($sformatf("l%0d_b2b_count", l), 12'(ack_cnt[l] >= 3), 12'd1);
        idle_ok = 1'b0;
        for (int c = 0; c < 40 && !idle_ok; c++) begin
            @(negedge clk);
            idle_ok = !busy_a[0] && !busy_a[1];
        end
        check_eq("drain_idle", 12'(idle_ok), 12'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
